r_channel_ctrl: RTL

- Read-data (R) stage of the AXI4-Lite slave read path, directly downstream of the AR stage.
- Consumes the read-enable pulse and address issued by the AR stage, waits for the memory's read data, and presents RDATA/RRESP to the master over the R handshake.
- Returns a one-cycle completion/retry feedback code that the AR stage consumes in its DONE state.
- Handles out-of-range decode (DECERR), memory-error retry and final SLVERR.

---
 rtl/axi_lite_pkg.sv | 26 ++
 rtl/r_timeout_timer.sv | 42 ++++
 rtl/r_channel_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: response/feedback codes and R-stage state encoding shared by the AXI4-Lite read path.
// Rev 1.0
`default_nettype none

package axi_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Codes returned to the AR stage on its RRESP input
  localparam logic [1:0] FB_DONE   = 2'b00;
  localparam logic [1:0] FB_RETRY  = 2'b01;
  localparam logic [1:0] FB_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE     = 2'd0,
    R_WAIT_MEM = 2'd1,
    R_RETRY    = 2'd2,
    R_RESP     = 2'd3
  } r_state_e;

endpackage

`default_nettype wire

// File: rtl/r_timeout_timer.sv
// r_timeout_timer: WAIT_MEM watchdog; cleared on load, expires on the TIMEOUT_CYCLES-th enabled cycle.
// Rev 1.0
`default_nettype none

module r_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/r_channel_ctrl.sv
// r_channel_ctrl: AXI4-Lite R stage with decode error, memory-error retry and SLVERR; retry/done feedback to AR.
// Optional WAIT_MEM timeout under macro R_TIMEOUT_EN. Rev 1.0
`default_nettype none

module r_channel_ctrl
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH      = 32,
  parameter int RETRY_MAX      = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  REN,
  input  logic [ADDR_WIDTH-1:0] RADDR,
  input  logic                  MEMRVALID,
  input  logic [DATA_WIDTH-1:0] MEMRDATA,
  input  logic                  MEMRERR,
  output logic                  RVALID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  input  logic                  RREADY,
  output logic                  FBVALID,
  output logic [1:0]            FBRESP
);

  localparam int CNT_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] RETRY_LIM = CNT_W'(RETRY_MAX);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  r_state_e              state_q, state_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  fbvalid_q, fbvalid_d;
  logic [1:0]            fbresp_q, fbresp_d;
  logic [CNT_W-1:0]      retry_cnt_q, retry_cnt_d;
  logic                  wait_entry;
  logic                  mem_fail;
  logic                  mem_timeout;

`ifdef R_TIMEOUT_EN
  r_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_timer (
    .clk    (clk),
    .resetn (resetn),
    .load   (wait_entry),
    .en     (state_q == R_WAIT_MEM),
    .expired(mem_timeout)
  );
`else
  assign mem_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    fbvalid_d   = 1'b0;
    fbresp_d    = fbresp_q;
    retry_cnt_d = retry_cnt_q;
    wait_entry  = 1'b0;
    // A real memory response always takes priority over a coincident timeout
    mem_fail    = MEMRVALID ? MEMRERR : mem_timeout;

    case (state_q)
      R_IDLE, R_RETRY: begin
        // REN during the feedback cycle itself is too early for the AR stage
        if (REN && !fbvalid_q) begin
          if ({1'b0, RADDR} >= DEPTH_LIM) begin
            rdata_d  = '0;
            rresp_d  = DECERR;
            rvalid_d = 1'b1;
            state_d  = R_RESP;
          end else begin
            wait_entry = 1'b1;
            state_d    = R_WAIT_MEM;
          end
        end
      end
      R_WAIT_MEM: begin
        if (MEMRVALID && !MEMRERR) begin
          rdata_d  = MEMRDATA;
          rresp_d  = OKAY;
          rvalid_d = 1'b1;
          state_d  = R_RESP;
        end else if (mem_fail) begin
          if (retry_cnt_q < RETRY_LIM) begin
            retry_cnt_d = retry_cnt_q + CNT_W'(1);
            fbvalid_d   = 1'b1;
            fbresp_d    = FB_RETRY;
            state_d     = R_RETRY;
          end else begin
            rdata_d  = '0;
            rresp_d  = SLVERR;
            rvalid_d = 1'b1;
            state_d  = R_RESP;
          end
        end
      end
      R_RESP: begin
        if (RREADY) begin
          rvalid_d    = 1'b0;
          fbvalid_d   = 1'b1;
          fbresp_d    = (rresp_q == DECERR) ? FB_DECERR : FB_DONE;
          retry_cnt_d = '0;
          state_d     = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= R_IDLE;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= OKAY;
      fbvalid_q   <= 1'b0;
      fbresp_q    <= FB_DONE;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      fbvalid_q   <= fbvalid_d;
      fbresp_q    <= fbresp_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign FBVALID = fbvalid_q;
  assign FBRESP  = fbresp_q;

endmodule

`default_nettype wire
